// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter.
package rr_arbiter_4_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  typedef logic [IDX_W-1:0] arb_idx_t;

  // Next requester after idx, wrapping 3 -> 0 through the 2-bit width.
  function automatic arb_idx_t next_idx(input arb_idx_t idx);
    return idx + arb_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter_4_if;
  import rr_arbiter_4_pkg::*;

  logic [NREQ-1:0] req;
  logic            done;
  logic            sel_a;
  logic            sel_b;
  logic            sel_en;
  logic            timeout;

  // Requester side drives req/done and observes the grant.
  modport master (
    output req, done,
    input  sel_a, sel_b, sel_en, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output sel_a, sel_b, sel_en, timeout
  );

endinterface

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first set request at or after start (mod 4).
module rr_pick_4
  import rr_arbiter_4_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] off;

  // Rotate so start sits at bit 0, take the lowest set bit, rotate the result back.
  always_comb begin
    rot = NREQ'({req, req} >> start);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    idx = start + off;
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters; drives a registered grant index
// and enable into the downstream 2-to-4 decoder.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int HOLD_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_4_if.slave bus
);

  localparam logic              HOLD_EN = (HOLD_MAX != 0);
  localparam logic [HOLD_W-1:0] LIMIT   = HOLD_EN ? HOLD_W'(HOLD_MAX - 1) : '0;

  arb_state_t        state;
  arb_idx_t          idx;
  arb_idx_t          ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  arb_idx_t pick_start;
  arb_idx_t pick_idx;
  logic     pick_any;
  logic     owner_drop;
  logic     limit_hit;
  logic     release_now;

  // Search origin: the pointer while idle, just past the owner on release.
  // Both equal idx+1 after any release, so one picker serves both cases.
  always_comb begin
    pick_start  = (state == ST_GRANT) ? next_idx(idx) : ptr;
    owner_drop  = bus.done || !bus.req[idx];
    limit_hit   = HOLD_EN && (hold_cnt == LIMIT);
    release_now = (state == ST_GRANT) && (owner_drop || limit_hit);
  end

  rr_pick_4 u_pick (
    .req   (bus.req),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // State machine:
  //   state    | meaning
  //   ST_IDLE  | no grant, sel_en low, waiting for any request
  //   ST_GRANT | idx owns the decoder; hold_cnt counts cycles owned
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state    <= ST_GRANT;
            idx      <= pick_idx;
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            ptr       <= next_idx(idx);
            // done or a dropped request wins over a coincident hold limit
            timeout_q <= limit_hit && !owner_drop;
            hold_cnt  <= '0;
            if (pick_any) begin
              idx <= pick_idx;
            end else begin
              state <= ST_IDLE;
            end
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sel_a   = idx[0];
  assign bus.sel_b   = idx[1];
  assign bus.sel_en  = (state == ST_GRANT);
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       t_rst = 1'b0;
  logic [3:0] t_req = 4'b0000;
  logic       t_done = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  rr_arbiter_4_if if8 ();
  rr_arbiter_4_if if0 ();

  assign if8.req  = t_req;
  assign if8.done = t_done;
  assign if0.req  = t_req;
  assign if0.done = t_done;

  rr_arbiter_4 #(.HOLD_MAX(8), .HOLD_W(4)) u8 (.clk(clk), .rst(t_rst), .bus(if8));
  rr_arbiter_4 #(.HOLD_MAX(0), .HOLD_W(4)) u0 (.clk(clk), .rst(t_rst), .bus(if0));

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models the HOLD_MAX=8 instance, index 1 the HOLD_MAX=0 instance.
  int m_en[2];
  int m_owner[2];
  int m_ptr[2];
  int m_held[2];
  int m_to[2];
  bit chk_on = 1'b0;
  int hold_max[2] = '{8, 0};

  function automatic int find_req(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int en, owner, ptr, held, to, w;
    bit dropped, limit;
    for (int d = 0; d < 2; d++) begin
      en = m_en[d]; owner = m_owner[d]; ptr = m_ptr[d]; held = m_held[d];
      to = 0;
      if (t_rst) begin
        en = 0; owner = 0; ptr = 0; held = 0;
      end else if (en == 0) begin
        w = find_req(t_req, ptr);
        if (w >= 0) begin en = 1; owner = w; held = 0; end
      end else begin
        dropped = t_done || !t_req[owner];
        limit   = (hold_max[d] != 0) && (held + 1 == hold_max[d]);
        if (dropped || limit) begin
          ptr = (owner + 1) % 4;
          to  = (limit && !dropped) ? 1 : 0;
          w   = find_req(t_req, ptr);
          if (w >= 0) begin owner = w; held = 0; end
          else en = 0;
        end else begin
          held = held + 1;
        end
      end
      m_en[d]    <= en;
      m_owner[d] <= owner;
      m_ptr[d]   <= ptr;
      m_held[d]  <= held;
      m_to[d]    <= to;
    end
    if (t_rst) chk_on <= 1'b1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("h8_sel_en",  8'(if8.sel_en),               8'(m_en[0]));
      check("h8_idx",     8'({if8.sel_b, if8.sel_a}),   8'(m_owner[0]));
      check("h8_timeout", 8'(if8.timeout),              8'(m_to[0]));
      check("h0_sel_en",  8'(if0.sel_en),               8'(m_en[1]));
      check("h0_idx",     8'({if0.sel_b, if0.sel_a}),   8'(m_owner[1]));
      check("h0_timeout", 8'(if0.timeout),              8'(m_to[1]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [3:0] r, input logic dn, input logic rs);
    @(negedge clk);
    t_req  = r;
    t_done = dn;
    t_rst  = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] idx8();
    return 8'({if8.sel_b, if8.sel_a});
  endfunction

  function automatic logic [7:0] idx0();
    return 8'({if0.sel_b, if0.sel_a});
  endfunction

  initial begin
    int exp_seq[4] = '{1, 2, 3, 0};
    int to8, to0, low0;

    // 1: reset with all requesting, first grant goes to 0
    for (int i = 0; i < 2; i++) begin
      step(4'b1111, 1'b0, 1'b1);
      check("rst_sel_en", 8'(if8.sel_en), 8'd0);
      check("rst_idx", idx8(), 8'd0);
      check("rst_timeout", 8'(if8.timeout), 8'd0);
    end
    step(4'b1111, 1'b0, 1'b0);
    check("first_grant_en", 8'(if8.sel_en), 8'd1);
    check("first_grant_idx", idx8(), 8'd0);
    check("model_first_idx", 8'(m_owner[0]), 8'd0);

    // 2: done every 2nd grant cycle rotates 0,1,2,3,0 without a bubble
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      check("rot_hold_en", 8'(if8.sel_en), 8'd1);
      step(4'b1111, 1'b1, 1'b0);
      check("rot_en", 8'(if8.sel_en), 8'd1);
      check("rot_idx", idx8(), 8'(exp_seq[i]));
    end

    // 3: lone requester 2 held; hold limit forces one release and re-grant
    step(4'b0100, 1'b0, 1'b0);
    check("lone_idx", idx8(), 8'd2);
    to8 = 0; to0 = 0;
    for (int k = 1; k <= 10; k++) begin
      step(4'b0100, 1'b0, 1'b0);
      to8 += int'(if8.timeout);
      to0 += int'(if0.timeout);
      check("lone_en", 8'(if8.sel_en), 8'd1);
      if (k == 8) check("limit_pulse", 8'(if8.timeout), 8'd1);
    end
    check("limit_pulse_count", 8'(to8), 8'd1);
    check("nolimit_pulse_count", 8'(to0), 8'd0);

    // 4: owner 3 done with req dropping to 0001 -> wrap to 0, no timeout
    step(4'b1000, 1'b0, 1'b0);
    check("own3_idx", idx8(), 8'd3);
    step(4'b0001, 1'b1, 1'b0);
    check("wrap_idx", idx8(), 8'd0);
    check("wrap_timeout", 8'(if8.timeout), 8'd0);
    for (int k = 0; k < 7; k++) step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    check("done_at_limit_timeout", 8'(if8.timeout), 8'd0);
    check("done_at_limit_idx", idx8(), 8'd0);
    check("done_at_limit_en", 8'(if8.sel_en), 8'd1);

    // 5: reset in the middle of a grant to 1 with hold_cnt = 5
    step(4'b0010, 1'b0, 1'b0);
    check("own1_idx", idx8(), 8'd1);
    for (int k = 0; k < 5; k++) step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    check("midrst_en", 8'(if8.sel_en), 8'd0);
    check("midrst_idx", idx8(), 8'd0);
    check("midrst_timeout", 8'(if8.timeout), 8'd0);
    step(4'b0010, 1'b0, 1'b0);
    check("postrst_idx", idx8(), 8'd1);
    check("postrst_en", 8'(if8.sel_en), 8'd1);

    // 6: single requester held 40 cycles; limit disabled instance never releases
    to8 = 0; to0 = 0; low0 = 0;
    for (int k = 0; k < 40; k++) begin
      step(4'b0010, 1'b0, 1'b0);
      to8 += int'(if8.timeout);
      to0 += int'(if0.timeout);
      if (if0.sel_en !== 1'b1 || idx0() !== 8'd1) low0++;
    end
    check("h8_40cyc_timeouts", 8'(to8), 8'd5);
    check("h0_40cyc_timeouts", 8'(to0), 8'd0);
    check("h0_40cyc_released", 8'(low0), 8'd0);

    // 7: idle holds last index, done in idle ignored, other req bits ignored mid-grant
    step(4'b0000, 1'b0, 1'b0);
    check("idle_en", 8'(if8.sel_en), 8'd0);
    check("idle_idx_held", idx8(), 8'd1);
    step(4'b0000, 1'b1, 1'b0);
    check("idle_done_en", 8'(if8.sel_en), 8'd0);
    step(4'b0100, 1'b0, 1'b0);
    check("from_ptr2_idx", idx8(), 8'd2);
    step(4'b1111, 1'b0, 1'b0);
    check("others_ignored_idx", idx8(), 8'd2);
    step(4'b1011, 1'b0, 1'b0);
    check("drop_to3_idx", idx8(), 8'd3);
    check("model_drop_to3", 8'(m_owner[0]), 8'd3);

    step(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
